// File: rtl/operand_fetch_if.sv
// Operand-fetch bus bundle: decoder handshake, register-file read port,
// writeback mirror and execute handshake, grouped so the stage and its
// environment can be wired with one connection.
`timescale 1ns/1ps
interface operand_fetch_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_rn;
   logic [3:0]  in_rm;
   logic [3:0]  in_rs;
   logic [2:0]  in_use;
   logic [31:0] in_pc;
   logic        rf_read_en;
   logic [3:0]  rf_read_reg;
   logic [31:0] rf_read_value;
   logic        wb_en;
   logic [3:0]  wb_reg;
   logic [31:0] wb_value;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rn_val;
   logic [31:0] out_rm_val;
   logic [31:0] out_rs_val;

   // The operand-fetch stage itself.
   modport slave (
      input  in_valid, in_rn, in_rm, in_rs, in_use, in_pc,
      output in_ready,
      output rf_read_en, rf_read_reg,
      input  rf_read_value,
      input  wb_en, wb_reg, wb_value,
      output out_valid, out_rn_val, out_rm_val, out_rs_val,
      input  out_ready
   );

   // The surrounding pipeline: decoder, register file and execute.
   modport master (
      output in_valid, in_rn, in_rm, in_rs, in_use, in_pc,
      input  in_ready,
      input  rf_read_en, rf_read_reg,
      output rf_read_value,
      output wb_en, wb_reg, wb_value,
      input  out_valid, out_rn_val, out_rm_val, out_rs_val,
      output out_ready
   );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads up to three source registers (Rn, Rm, Rs) one at
// a time through a single registered register-file read port, substitutes
// PC+PC_OFFSET for r15 and forwards writebacks that race the read.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// the offering side holds its payload stable until that edge.
`timescale 1ns/1ps
module operand_fetch #(
   parameter logic [31:0] PC_OFFSET = 32'd8
) (
   input  logic           clk,
   input  logic           rst_n,
   operand_fetch_if.slave bus,
   output logic [1:0]     o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [3:0]  r_rn;
   logic [3:0]  r_rm;
   logic [3:0]  r_rs;
   logic [2:0]  r_pending;
   logic [31:0] r_pc;
   logic [31:0] r_rn_val;
   logic [31:0] r_rm_val;
   logic [31:0] r_rs_val;
   logic        r_bypass;
   logic [31:0] r_bypass_val;

   logic        w_any;
   logic [1:0]  w_sel;
   logic [3:0]  w_idx;
   logic [2:0]  w_sel_mask;
   logic        w_wb_hit;
   logic        w_slot_we;
   logic [31:0] w_slot_val;
   logic        w_in_ready;
   logic        w_out_valid;
   logic        w_rf_read_en;
   logic [3:0]  w_rf_read_reg;

   // Pick the lowest pending operand slot and detect a writeback to its index.
   always_comb begin
      w_any = |r_pending;
      w_sel = 2'd0;
      w_idx = r_rn;
      if (r_pending[0]) begin
         w_sel = 2'd0;
         w_idx = r_rn;
      end else if (r_pending[1]) begin
         w_sel = 2'd1;
         w_idx = r_rm;
      end else if (r_pending[2]) begin
         w_sel = 2'd2;
         w_idx = r_rs;
      end
      w_sel_mask = 3'b001 << w_sel;
      // r15 always reads as the PC, so a writeback to it is never forwarded.
      w_wb_hit = bus.wb_en && (bus.wb_reg == w_idx) && (w_idx != 4'd15);
   end

   // Next-state decode, handshake outputs, read-port drive and slot writes.
   always_comb begin
      w_state_next  = r_state;
      w_in_ready    = 1'b0;
      w_out_valid   = 1'b0;
      w_rf_read_en  = 1'b0;
      w_rf_read_reg = 4'd0;
      w_slot_we     = 1'b0;
      w_slot_val    = 32'd0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (!w_any) begin
               w_state_next = S_DONE;
            end else if (w_idx == 4'd15) begin
               // PC substitution costs one cycle and no register-file read.
               w_slot_we  = 1'b1;
               w_slot_val = r_pc + PC_OFFSET;
            end else begin
               w_rf_read_en  = 1'b1;
               w_rf_read_reg = w_idx;
               w_state_next  = S_WAIT;
            end
         end
         S_WAIT: begin
            // A writeback this cycle is newest; one during issue beats the stale read.
            w_slot_we = 1'b1;
            if (w_wb_hit)
               w_slot_val = bus.wb_value;
            else if (r_bypass)
               w_slot_val = r_bypass_val;
            else
               w_slot_val = bus.rf_read_value;
            w_state_next = S_ISSUE;
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Instruction latch, operand slots, pending mask and issue-time bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rn         <= 4'd0;
         r_rm         <= 4'd0;
         r_rs         <= 4'd0;
         r_pending    <= 3'd0;
         r_pc         <= 32'd0;
         r_rn_val     <= 32'd0;
         r_rm_val     <= 32'd0;
         r_rs_val     <= 32'd0;
         r_bypass     <= 1'b0;
         r_bypass_val <= 32'd0;
      end else begin
         if (r_state == S_IDLE && bus.in_valid) begin
            r_rn      <= bus.in_rn;
            r_rm      <= bus.in_rm;
            r_rs      <= bus.in_rs;
            r_pending <= bus.in_use;
            r_pc      <= bus.in_pc;
            r_rn_val  <= 32'd0;
            r_rm_val  <= 32'd0;
            r_rs_val  <= 32'd0;
            r_bypass  <= 1'b0;
         end
         if (w_slot_we) begin
            case (w_sel)
               2'd0:    r_rn_val <= w_slot_val;
               2'd1:    r_rm_val <= w_slot_val;
               default: r_rs_val <= w_slot_val;
            endcase
            r_pending <= r_pending & ~w_sel_mask;
         end
         if (w_rf_read_en) begin
            r_bypass     <= w_wb_hit;
            r_bypass_val <= bus.wb_value;
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = w_out_valid;
   assign bus.rf_read_en  = w_rf_read_en;
   assign bus.rf_read_reg = w_rf_read_reg;
   assign bus.out_rn_val  = r_rn_val;
   assign bus.out_rm_val  = r_rm_val;
   assign bus.out_rs_val  = r_rs_val;
   assign o_dbg_state     = r_state;

endmodule
